// File: rtl/mem_stage.sv
// RV32I memory-access stage: data-memory request/ack port, load extension,
// wait-state stall control and the MEM/WB pipeline register.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_ResultM,
    input  logic [31:0] i_DataStoreM,
    input  logic [2:0]  i_Func3M,
    input  logic [4:0]  i_RdM,
    input  logic        i_RegSrcM,
    input  logic        i_MemSrcM,
    input  logic        i_LoadM,
    input  logic [1:0]  i_ResultSrcM,
    input  logic [31:0] i_PcM,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic [31:0] o_ResultW,
    output logic [31:0] o_ReadDataW,
    output logic [31:0] o_PcW,
    output logic [4:0]  o_RdW,
    output logic        o_RegSrcW,
    output logic [1:0]  o_ResultSrcW
);
    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic        state_q, state_d;
    logic [31:0] h_result_q, h_result_d, h_wdata_q, h_wdata_d, h_pc_q, h_pc_d;
    logic        h_we_q, h_we_d, h_regsrc_q, h_regsrc_d;
    logic [3:0]  h_wstrb_q, h_wstrb_d;
    logic [2:0]  h_func3_q, h_func3_d;
    logic [4:0]  h_rd_q, h_rd_d;
    logic [1:0]  h_ressrc_q, h_ressrc_d;
    logic [31:0] result_w_q, result_w_d, rdata_w_q, rdata_w_d, pc_w_q, pc_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic        regsrc_w_q, regsrc_w_d, fault_q, fault_d;
    logic [1:0]  ressrc_w_q, ressrc_w_d;

    logic        access, legal, misal, fault_in, stall;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Decode of the incoming EX/MEM bundle; a simultaneous load+store is a load.
    always_comb begin
        access = i_LoadM | i_MemSrcM;
        if (i_LoadM)
            legal = (i_Func3M == 3'b000) || (i_Func3M == 3'b001) || (i_Func3M == 3'b010) ||
                    (i_Func3M == 3'b100) || (i_Func3M == 3'b101);
        else
            legal = (i_Func3M == 3'b000) || (i_Func3M == 3'b001) || (i_Func3M == 3'b010);
        misal    = ((i_Func3M[1:0] == 2'b01) && i_ResultM[0]) ||
                   ((i_Func3M[1:0] == 2'b10) && (i_ResultM[1:0] != 2'b00));
        fault_in = access && (!legal || misal);
        case (i_Func3M[1:0])
            2'b00: begin
                in_wstrb = 4'b0001 << i_ResultM[1:0];
                in_wdata = {4{i_DataStoreM[7:0]}};
            end
            2'b01: begin
                in_wstrb = i_ResultM[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{i_DataStoreM[15:0]}};
            end
            default: begin
                in_wstrb = 4'b1111;
                in_wdata = i_DataStoreM;
            end
        endcase
        if (i_LoadM)
            in_wstrb = 4'b0000;
    end

    always_comb begin
        state_d    = state_q;
        h_result_d = h_result_q;
        h_wdata_d  = h_wdata_q;
        h_pc_d     = h_pc_q;
        h_we_d     = h_we_q;
        h_regsrc_d = h_regsrc_q;
        h_wstrb_d  = h_wstrb_q;
        h_func3_d  = h_func3_q;
        h_rd_d     = h_rd_q;
        h_ressrc_d = h_ressrc_q;
        result_w_d = 32'h0;
        rdata_w_d  = 32'h0;
        pc_w_d     = 32'h0;
        rd_w_d     = 5'h0;
        regsrc_w_d = 1'b0;
        ressrc_w_d = 2'b00;
        fault_d    = 1'b0;
        stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = 32'h0;
        o_dmem_wdata = 32'h0;
        o_dmem_wstrb = 4'h0;
        if (state_q == S_WAIT) begin
            o_dmem_req   = 1'b1;
            o_dmem_we    = h_we_q;
            o_dmem_addr  = {h_result_q[31:2], 2'b00};
            o_dmem_wdata = h_wdata_q;
            o_dmem_wstrb = h_wstrb_q;
            if (i_dmem_ack) begin
                result_w_d = h_result_q;
                rdata_w_d  = h_we_q ? 32'h0 : load_ext(h_func3_q, h_result_q[1:0], i_dmem_rdata);
                pc_w_d     = h_pc_q;
                rd_w_d     = h_rd_q;
                regsrc_w_d = h_regsrc_q;
                ressrc_w_d = h_ressrc_q;
                state_d    = S_IDLE;
            end else begin
                stall = 1'b1;
            end
        end else if (access && !fault_in) begin
            o_dmem_req   = 1'b1;
            o_dmem_we    = !i_LoadM;
            o_dmem_addr  = {i_ResultM[31:2], 2'b00};
            o_dmem_wdata = i_LoadM ? 32'h0 : in_wdata;
            o_dmem_wstrb = in_wstrb;
            if (i_dmem_ack) begin
                result_w_d = i_ResultM;
                rdata_w_d  = i_LoadM ? load_ext(i_Func3M, i_ResultM[1:0], i_dmem_rdata) : 32'h0;
                pc_w_d     = i_PcM;
                rd_w_d     = i_RdM;
                regsrc_w_d = i_RegSrcM;
                ressrc_w_d = i_ResultSrcM;
            end else begin
                h_result_d = i_ResultM;
                h_wdata_d  = o_dmem_wdata;
                h_pc_d     = i_PcM;
                h_we_d     = !i_LoadM;
                h_regsrc_d = i_RegSrcM;
                h_wstrb_d  = in_wstrb;
                h_func3_d  = i_Func3M;
                h_rd_d     = i_RdM;
                h_ressrc_d = i_ResultSrcM;
                stall      = 1'b1;
                state_d    = S_WAIT;
            end
        end else begin
            // Non-access or faulting access: pass straight through, faults never write rd.
            result_w_d = i_ResultM;
            pc_w_d     = i_PcM;
            rd_w_d     = i_RdM;
            regsrc_w_d = i_RegSrcM && !fault_in;
            ressrc_w_d = i_ResultSrcM;
            fault_d    = fault_in;
        end
        if (rst) begin
            o_dmem_req = 1'b0;
            stall      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            h_result_q <= 32'h0;
            h_wdata_q  <= 32'h0;
            h_pc_q     <= 32'h0;
            h_we_q     <= 1'b0;
            h_regsrc_q <= 1'b0;
            h_wstrb_q  <= 4'h0;
            h_func3_q  <= 3'h0;
            h_rd_q     <= 5'h0;
            h_ressrc_q <= 2'b00;
            result_w_q <= 32'h0;
            rdata_w_q  <= 32'h0;
            pc_w_q     <= 32'h0;
            rd_w_q     <= 5'h0;
            regsrc_w_q <= 1'b0;
            ressrc_w_q <= 2'b00;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_result_q <= h_result_d;
            h_wdata_q  <= h_wdata_d;
            h_pc_q     <= h_pc_d;
            h_we_q     <= h_we_d;
            h_regsrc_q <= h_regsrc_d;
            h_wstrb_q  <= h_wstrb_d;
            h_func3_q  <= h_func3_d;
            h_rd_q     <= h_rd_d;
            h_ressrc_q <= h_ressrc_d;
            result_w_q <= result_w_d;
            rdata_w_q  <= rdata_w_d;
            pc_w_q     <= pc_w_d;
            rd_w_q     <= rd_w_d;
            regsrc_w_q <= regsrc_w_d;
            ressrc_w_q <= ressrc_w_d;
            fault_q    <= fault_d;
        end
    end

    assign o_stall      = stall;
    assign o_fault      = fault_q;
    assign o_ResultW    = result_w_q;
    assign o_ReadDataW  = rdata_w_q;
    assign o_PcW        = pc_w_q;
    assign o_RdW        = rd_w_q;
    assign o_RegSrcW    = regsrc_w_q;
    assign o_ResultSrcW = ressrc_w_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model answering the bus, directed
// test-plan steps followed by randomized accesses with random wait states.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_ResultM = '0, i_DataStoreM = '0, i_PcM = '0, i_dmem_rdata = '0;
    logic [2:0]  i_Func3M = '0;
    logic [4:0]  i_RdM = '0;
    logic        i_RegSrcM = 1'b0, i_MemSrcM = 1'b0, i_LoadM = 1'b0, i_dmem_ack = 1'b0;
    logic [1:0]  i_ResultSrcM = '0;
    logic        o_dmem_req, o_dmem_we, o_stall, o_fault, o_RegSrcW;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_ResultW, o_ReadDataW, o_PcW;
    logic [3:0]  o_dmem_wstrb;
    logic [4:0]  o_RdW;
    logic [1:0]  o_ResultSrcW;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] mem_b [int unsigned];

    mem_stage dut (
        .clk(clk), .rst(rst), .i_ResultM(i_ResultM), .i_DataStoreM(i_DataStoreM),
        .i_Func3M(i_Func3M), .i_RdM(i_RdM), .i_RegSrcM(i_RegSrcM), .i_MemSrcM(i_MemSrcM),
        .i_LoadM(i_LoadM), .i_ResultSrcM(i_ResultSrcM), .i_PcM(i_PcM),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .o_fault(o_fault),
        .o_ResultW(o_ResultW), .o_ReadDataW(o_ReadDataW), .o_PcW(o_PcW), .o_RdW(o_RdW),
        .o_RegSrcW(o_RegSrcW), .o_ResultSrcW(o_ResultSrcW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : 8'h00;
    endfunction

    function automatic logic [31:0] bus_word(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFFC;
        return {rb(base + 3), rb(base + 2), rb(base + 1), rb(base)};
    endfunction

    // One instruction through the stage, with the memory answering after `waits` cycles.
    task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic rs, input int waits);
        int          size;
        logic        access, legal, fault, go;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_rdata, pc;
        logic [1:0]  rsrc;
        access = ld | st;
        size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (ld) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else    legal = f3 inside {3'd0, 3'd1, 3'd2};
        fault = access && (!legal || (addr % size) != 0);
        go    = access && !fault;
        pc    = $urandom;
        rsrc  = 2'($urandom_range(0, 3));
        e_strb  = '0;
        e_wdata = '0;
        if (st && !ld) begin
            for (int i = 0; i < size; i++) e_strb[(addr + i) & 3] = 1'b1;
            for (int j = 0; j < 4; j++) e_wdata[8*j +: 8] = data[8*(j % size) +: 8];
        end
        e_rdata = '0;
        if (ld && go) begin
            for (int i = 0; i < size; i++) e_rdata = e_rdata | (32'(rb(addr + i)) << (8*i));
            if (!f3[2] && size < 4 && e_rdata[8*size-1]) e_rdata = e_rdata | (32'hFFFF_FFFF << (8*size));
        end
        i_ResultM = addr; i_DataStoreM = data; i_Func3M = f3; i_RdM = rd; i_RegSrcM = rs;
        i_MemSrcM = st; i_LoadM = ld; i_ResultSrcM = rsrc; i_PcM = pc;
        i_dmem_ack   = go && (waits == 0);
        i_dmem_rdata = bus_word(addr);
        #1;
        chk("req", 32'(o_dmem_req), 32'(go));
        chk("stall", 32'(o_stall), 32'(go && waits > 0));
        if (go) begin
            chk("addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
            chk("we", 32'(o_dmem_we), 32'(!ld));
            chk("wstrb", 32'(o_dmem_wstrb), 32'(e_strb));
            if (!ld) chk("wdata", o_dmem_wdata, e_wdata);
            for (int k = 1; k <= waits; k++) begin
                @(posedge clk); #1;
                chk("bubble_rd", 32'(o_RdW), 32'h0);
                chk("bubble_regsrc", 32'(o_RegSrcW), 32'h0);
                chk("bubble_result", o_ResultW, 32'h0);
                i_ResultM = $urandom; i_DataStoreM = $urandom; i_Func3M = 3'($urandom);
                i_RdM = 5'($urandom); i_LoadM = 1'($urandom); i_MemSrcM = 1'($urandom);
                i_PcM = $urandom;
                i_dmem_ack   = (k == waits);
                i_dmem_rdata = (k == waits) ? bus_word(addr) : $urandom;
                #1;
                chk("wait_req", 32'(o_dmem_req), 32'h1);
                chk("wait_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
                chk("wait_wstrb", 32'(o_dmem_wstrb), 32'(e_strb));
                if (!ld) chk("wait_wdata", o_dmem_wdata, e_wdata);
                chk("wait_stall", 32'(o_stall), 32'(k != waits));
            end
        end
        @(posedge clk); #1;
        i_dmem_ack = 1'b0;
        if (go && !ld)
            for (int i = 0; i < size; i++) mem_b[addr + i] = data[8*i +: 8];
        chk("wb_result", o_ResultW, addr);
        chk("wb_rd", 32'(o_RdW), 32'(rd));
        chk("wb_regsrc", 32'(o_RegSrcW), 32'(rs && !fault));
        chk("wb_ressrc", 32'(o_ResultSrcW), 32'(rsrc));
        chk("wb_pc", o_PcW, pc);
        chk("wb_rdata", o_ReadDataW, e_rdata);
        chk("fault", 32'(o_fault), 32'(fault));
    endtask

    initial begin
        i_LoadM = 1'b1; i_dmem_ack = 1'b1; i_ResultM = 32'h100; i_Func3M = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(o_dmem_req), 32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_result", o_ResultW, 32'h0);
        chk("rst_rd", 32'(o_RdW), 32'h0);
        chk("rst_regsrc", 32'(o_RegSrcW), 32'h0);
        chk("rst_fault", 32'(o_fault), 32'h0);
        i_LoadM = 1'b0; i_dmem_ack = 1'b0;
        rst = 1'b0;

        mem_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 0);
        mem_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1, 0);
        chk("lw_plan", o_ReadDataW, 32'hDEADBEEF);
        mem_op(1'b0, 1'b1, 3'b010, 32'h100, 32'h80FF7F01, 5'd0, 1'b0, 0);
        mem_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd4, 1'b1, 0);
        chk("lb_plan", o_ReadDataW, 32'hFFFFFF80);
        mem_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 1'b1, 0);
        mem_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd4, 1'b1, 0);
        chk("lh_plan", o_ReadDataW, 32'hFFFF80FF);
        mem_op(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 5'd4, 1'b1, 0);
        mem_op(1'b0, 1'b1, 3'b000, 32'h102, 32'h000000AB, 5'd0, 1'b0, 0);
        mem_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd9, 1'b1, 3);
        mem_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 1'b1, 0);
        mem_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd6, 1'b1, 0);
        mem_op(1'b0, 1'b1, 3'b001, 32'h101, 32'h1234, 5'd0, 1'b0, 0);
        mem_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 0);

        // Reset two cycles into a wait, then a spurious ack with nothing outstanding.
        i_LoadM = 1'b1; i_MemSrcM = 1'b0; i_Func3M = 3'b010; i_ResultM = 32'h100;
        i_RdM = 5'd8; i_RegSrcM = 1'b1; i_dmem_ack = 1'b0;
        #1;
        chk("rw_stall0", 32'(o_stall), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; i_LoadM = 1'b0;
        #1;
        chk("rw_req_in_rst", 32'(o_dmem_req), 32'h0);
        @(posedge clk); #1;
        chk("rw_req", 32'(o_dmem_req), 32'h0);
        chk("rw_stall", 32'(o_stall), 32'h0);
        chk("rw_result", o_ResultW, 32'h0);
        chk("rw_rdata", o_ReadDataW, 32'h0);
        chk("rw_pc", o_PcW, 32'h0);
        chk("rw_rd", 32'(o_RdW), 32'h0);
        chk("rw_regsrc", 32'(o_RegSrcW), 32'h0);
        rst = 1'b0;
        i_ResultM = 32'h55; i_RdM = 5'd7; i_RegSrcM = 1'b1; i_dmem_ack = 1'b1;
        #1;
        chk("spur_req", 32'(o_dmem_req), 32'h0);
        chk("spur_stall", 32'(o_stall), 32'h0);
        @(posedge clk); #1;
        i_dmem_ack = 1'b0;
        chk("spur_rd", 32'(o_RdW), 32'd7);
        chk("spur_rdata", o_ReadDataW, 32'h0);
        chk("spur_result", o_ResultW, 32'h55);

        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic        ld, st;
            kind = $urandom_range(0, 9);
            ld = (kind < 4) || (kind == 8);
            st = (kind >= 4 && kind < 8) || (kind == 8);
            mem_op(ld, st, 3'($urandom_range(0, 7)), 32'h200 + $urandom_range(0, 31),
                   $urandom, 5'($urandom), ld ? 1'b1 : (st ? 1'b0 : 1'($urandom)),
                   $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
